store_queue_ctrl: RTL
=====================

// Module: store_queue_ctrl
// PURPOSE
//  Store sequencer between the MEM stage and the data-memory write port.
//  Accepts SB/SH/SW requests, aligns data into byte lanes, generates byte enables and queues them in a small FIFO.
//  Issues writes to memory with a req/ack handshake and back-pressures the pipeline when full.
//  Flags load-after-store hazards against pending entries so the hazard unit can stall loads.
// PARAMETERS
//  DEPTH   4   queue entries; power of two, >= 2
//  ADDR_W  32  byte-address width
// PORTS
//  clk            in   1       rising-edge clock
//  reset          in   1       synchronous, active-high
//  st_valid       in   1       MEM stage presents a store
//  st_ready       out  1       queue can accept (= !full)
//  st_addr        in   ADDR_W  byte address
//  st_data        in   32      unaligned rs2 value (low byte/half significant)
//  st_func        in   6       SB=6'b010000, SH=6'b010001, SW=6'b010010
//  st_misalign    out  1       1-cycle pulse: accepted store was misaligned and dropped
//  ld_check       in   1       a load is in MEM this cycle
//  ld_addr        in   ADDR_W  load byte address
//  ld_hazard      out  1       combinational: pending entry hits the same word
//  mem_wr_req     out  1       write request to data memory
//  mem_wr_addr    out  ADDR_W  word-aligned address ([1:0]=0)
//  mem_wr_data    out  32      lane-aligned data
//  mem_wr_be      out  4       byte enables
//  mem_wr_ack     in   1       memory accepted the current write
//  empty          out  1       no pending stores (fence/drain use)
// BEHAVIOUR
//  - Reset: pointers=0, count=0, st_ready=1, empty=1, mem_wr_req=0, mem_wr_addr/data/be=0, st_misalign=0.
//    Reset mid-transfer abandons the in-flight write and all queued entries.
//  - Accept: st_valid & st_ready. st_ready depends only on full; no bypass when full even if ack pops the head.
//  - Align:
//    SB: data = {4{st_data[7:0]}}, be = 4'b0001 << addr[1:0].
//    SH: data = {2{st_data[15:0]}}, be = addr[1] ? 4'b1100 : 4'b0011.
//    SW: data = st_data, be = 4'b1111. Any other st_func is treated as SW.
//  - Misalign: SH with addr[0]=1, or SW with addr[1:0]!=0. The store is accepted and not enqueued;
//    st_misalign is high the next cycle.
//  - FSM on the head:
//    IDLE (empty) -> ISSUE when count becomes nonzero.
//    ISSUE: mem_wr_req=1; addr/data/be are registered from the head and stable until ack.
//    ISSUE + ack: pop. Stay in ISSUE with the next head on the next cycle if count>1, else go to IDLE.
//  - Latency: a store accepted in cycle N into an empty queue raises mem_wr_req in cycle N+1.
//    Ack is legal in the first req cycle, giving one write per cycle when ack is held high.
//  - Simultaneous push+pop: count is unchanged and FIFO order is preserved. Push into an empty queue
//    while the old head is popping is a normal enqueue.
//  - Count is $clog2(DEPTH)+1 bits wide. Read/write pointers wrap modulo DEPTH.
//    Full = (count==DEPTH); empty = (count==0).
//  - ld_hazard = ld_check & any valid entry (including the in-flight head) with addr[ADDR_W-1:2] == ld_addr[ADDR_W-1:2].
//    Byte enables are not compared (conservative).
//  - mem_wr_ack while mem_wr_req=0 is ignored.
// STRUCTURE
//  - Shared package store_pkg: the st_func constants (SB/SH/SW codes) and the entry struct/width
//    {addr[ADDR_W-1:2], data[31:0], be[3:0]}.
//  - Sub-module store_lane_align (combinational): st_func, addr[1:0], st_data -> lane data, be, misalign.
//  - Top level holds the FIFO storage, pointers/count, issue FSM and the hazard comparator.
// TESTING
//  1. SB addr=0x103, data=0x000000A5, ack same cycle -> next cycle req=1, addr=0x100, data=0xA5A5A5A5, be=4'b1000; empty=1 after.
//  2. SH addr=0x202, data=0x0000BEEF -> data=0xBEEFBEEF, be=4'b1100. SH addr=0x201 -> st_misalign pulse, no mem_wr_req.
//  3. Five SW with ack held low (DEPTH=4) -> st_ready=0 after the 4th; release ack -> writes issue in order, one per cycle, 5th accepted once not full.
//  4. Queue holds SW 0x300; load 0x302 with ld_check=1 -> ld_hazard=1. Load 0x304 -> ld_hazard=0. After ack, load 0x302 -> ld_hazard=0.
//  5. Full queue, push attempted in the same cycle as ack -> push refused (st_ready=0), count goes 4->3, order intact.
//  6. reset asserted during ISSUE with 3 entries -> next cycle mem_wr_req=0, empty=1, st_ready=1; a following SW issues normally.

Source files
------------

// File: rtl/store_pkg.sv
// Types and constants shared by the store queue: function codes, lane payload, FSM states.
// A queue entry is the word address followed by a lane_t; the top level sizes the address part.
package store_pkg;

    localparam logic [5:0] FUNC_SB = 6'b010000;
    localparam logic [5:0] FUNC_SH = 6'b010001;
    localparam logic [5:0] FUNC_SW = 6'b010010;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  be;
    } lane_t;

    localparam int LANE_W = $bits(lane_t);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } issue_state_e;

endpackage

// File: rtl/store_lane_align.sv
// Replicates store data into the addressed byte lanes and builds byte enables.
// Unknown function codes behave as SW.
module store_lane_align
    import store_pkg::*;
(
    input  logic [5:0]  func,
    input  logic [1:0]  byteOff,
    input  logic [31:0] rawData,
    output lane_t       lane,
    output logic        misalign
);

    always_comb begin
        // NOTE: every output gets a default first so no path can leave it unassigned (no latch).
        lane.data = rawData;
        lane.be   = 4'b1111;
        misalign  = |byteOff;
        case (func)
            FUNC_SB: begin
                lane.data = {4{rawData[7:0]}};
                lane.be   = 4'b0001 << byteOff;
                misalign  = 1'b0;
            end
            FUNC_SH: begin
                lane.data = {2{rawData[15:0]}};
                lane.be   = byteOff[1] ? 4'b1100 : 4'b0011;
                misalign  = byteOff[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/store_queue_ctrl.sv
// Store FIFO between MEM and the data-memory write port: aligns, queues, issues with req/ack,
// and flags loads that touch a word still pending in the queue.
module store_queue_ctrl
    import store_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [31:0]       st_data,
    input  logic [5:0]        st_func,
    output logic              st_misalign,
    input  logic              ld_check,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_hazard,
    output logic              mem_wr_req,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [31:0]       mem_wr_data,
    output logic [3:0]        mem_wr_be,
    input  logic              mem_wr_ack,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:2] wordAddr;
        lane_t             lane;
    } entry_t;

    entry_t           queueMem [DEPTH];
    logic [PTR_W-1:0] rdPtr, wrPtr;
    logic [CNT_W-1:0] count, countAfterPop;
    issue_state_e     state, nextState;
    lane_t            alignedLane;
    logic             alignMisalign;
    entry_t           inEntry, nextHead;
    logic             accept, push, pop, full, loadHead;
    logic [1:0]       unusedLdOffset;

    store_lane_align u_align (
        .func    (st_func),
        .byteOff (st_addr[1:0]),
        .rawData (st_data),
        .lane    (alignedLane),
        .misalign(alignMisalign)
    );

    assign inEntry       = '{wordAddr: st_addr[ADDR_W-1:2], lane: alignedLane};
    assign full          = (count == CNT_W'(DEPTH));
    assign st_ready      = !full;
    assign accept        = st_valid && st_ready;
    assign push          = accept && !alignMisalign;
    assign pop           = mem_wr_req && mem_wr_ack;
    assign countAfterPop = count - CNT_W'(pop);
    assign unusedLdOffset = ld_addr[1:0];

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (push) nextState = ISSUE;
            ISSUE:   if (pop && countAfterPop == '0 && !push) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        mem_wr_req = (state == ISSUE);
        empty      = (count == '0);
    end

    // The output registers take the head that will exist after this edge; when the queue
    // drains to nothing in the same cycle a store arrives, that head is the arriving store.
    assign loadHead = (nextState == ISSUE) && ((state == IDLE) || pop);
    assign nextHead = (countAfterPop == '0) ? inEntry : queueMem[rdPtr + PTR_W'(1)];

    always_ff @(posedge clk) begin
        if (reset) begin
            rdPtr       <= '0;
            wrPtr       <= '0;
            count       <= '0;
            st_misalign <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
            mem_wr_be   <= '0;
        end else begin
            st_misalign <= accept && alignMisalign;
            count       <= count + CNT_W'(push) - CNT_W'(pop);
            if (push) wrPtr <= wrPtr + PTR_W'(1);
            if (pop)  rdPtr <= rdPtr + PTR_W'(1);
            if (loadHead) begin
                mem_wr_addr <= {nextHead.wordAddr, 2'b00};
                mem_wr_data <= nextHead.lane.data;
                mem_wr_be   <= nextHead.lane.be;
            end
        end
    end

    // NOTE: storage is not reset; count alone decides which slots hold live entries.
    always_ff @(posedge clk) begin
        if (push) queueMem[wrPtr] <= inEntry;
    end

    always_comb begin
        ld_hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < count &&
                queueMem[rdPtr + PTR_W'(i)].wordAddr == ld_addr[ADDR_W-1:2])
                ld_hazard = 1'b1;
        end
        ld_hazard = ld_hazard && ld_check;
    end

endmodule
